shift_add_multiplier: RTL and testbench
=======================================

// Module: shift_add_multiplier
// PURPOSE
//  Sequential unsigned N x N -> 2N multiplier, for the M-extension datapath.
//  Each RUN cycle, the RCA adds the multiplicand into the upper half of the
//  accumulator, then a right shift consumes one multiplier bit.
//  Sits downstream of operand decode and upstream of writeback.
//  Start/busy/done handshake; N cycles per product.
// PARAMETERS
//  N      8   operand width in bits; product is 2N bits
// PORTS
//  clk      in   1    system clock; all state updates on the rising edge
//  rst_n    in   1    asynchronous active-low reset
//  start    in   1    request a multiply; sampled only in IDLE or DONE
//  a        in   N    multiplicand, captured on accepted start
//  b        in   N    multiplier, captured on accepted start
//  busy     out  1    high while in RUN
//  done     out  1    one-cycle pulse: product valid and final
//  product  out  2N   result; held stable from done until next accepted start
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, busy=0, done=0, product=0,
//   internal mcand/acc/count=0. Takes effect immediately, mid-RUN included;
//   the partial result is discarded and no done is issued.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: start=1 -> RUN. Capture mcand<=a; acc<={N'b0,b}; count<=0.
//   RUN: each cycle:
//    - if acc[0]=1, the upper sum is {1'b0,acc[2N-1:N]} + {1'b0,mcand}
//      (an N+1-bit RCA instance, zero-extended operands); otherwise it is
//      {1'b0,acc[2N-1:N]}.
//    - then acc <= {sum[N:0], acc[N-1:1]}, i.e. a right shift by one that
//      takes in the carry.
//    - count <= count+1. When count==N-1 -> DONE.
//    - RUN lasts exactly N cycles; start is ignored during RUN.
//   DONE: exactly one cycle.
//    - done=1; product=acc.
//    - start=1 in DONE is accepted: same capture as IDLE, next state RUN.
//    - otherwise next state IDLE.
//  Latency: start accepted at edge k -> done high during cycle k+N+1
//   (N RUN cycles, then the DONE cycle).
//  Throughput: one product every N+1 cycles, back-to-back.
//  Output timing and product updates:
//   - busy and done are registered (state-decoded); no combinational path
//     from start.
//   - product is loaded only on the edge entering DONE; it does not change
//     during RUN.
//  Width rules:
//   - count width $clog2(N+1).
//   - Unsigned only; no overflow is possible (2N-bit result).
//   - The RCA carry-out is absorbed as bit N of the N+1-bit sum.
//  Boundary conditions:
//   - a=0 or b=0 -> product 0 after the full N cycles (no early exit).
//   - start held high continuously -> re-accepted in every DONE state.
//   - a/b changes after capture have no effect.
// TESTING
//  1. N=8: a=13, b=11, start pulse -> busy for 8 cycles; done at cycle 9;
//     product=143.
//  2. a=255, b=255 -> product=65025 (16'hFE01); exercises a carry on every
//     add.
//  3. a=0, b=200, then a=200, b=0 -> product=0 both times; done still at
//     cycle 9.
//  4. Start 6*7; pulse start again and change a/b at RUN cycle 3 ->
//     ignored; product=42.
//  5. Start 100*3; assert rst_n=0 at RUN cycle 4 -> busy, done, product
//     all 0 immediately. After release, 5*5 -> product=25.
//  6. start held high, a=2, b=3, then a=4, b=5 at DONE -> done pulses
//     9 cycles apart; products 6 then 20.

Source files
------------

// File: rtl/shift_add_multiplier_if.sv
// Operand/result bundle between operand decode, the multiplier and writeback.
// start/a/b flow in; busy/done/product flow back out.
interface shift_add_multiplier_if #(
    parameter int N = 8
);
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned NxN->2N shift-add multiplier.
// N RUN cycles plus one DONE cycle per product; start is ignored while busy.
module shift_add_multiplier #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shift_add_multiplier_if.slave mul
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam int              CW   = $clog2(N + 1);
    localparam logic [CW-1:0]   LAST = CW'(N - 1);

    state_t           state_q, state_d;
    logic [N-1:0]     mcand_q, mcand_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [2*N-1:0]   product_q, product_d;
    logic [CW-1:0]    count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [N:0]       rca_sum;
    logic [N:0]       upper;
    logic [2*N-1:0]   acc_shift;

    // N+1-bit ripple-carry adder; the top bit of the sum holds the carry-out.
    always_comb begin
        logic [N:0] x;
        logic [N:0] y;
        logic       c;
        x       = {1'b0, acc_q[2*N-1:N]};
        y       = {1'b0, mcand_q};
        c       = 1'b0;
        rca_sum = '0;
        for (int i = 0; i <= N; i++) begin
            rca_sum[i] = x[i] ^ y[i] ^ c;
            c          = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
    end

    assign upper     = acc_q[0] ? rca_sum : {1'b0, acc_q[2*N-1:N]};
    assign acc_shift = {upper, acc_q[N-1:1]};

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (mul.start) begin
                    state_d = S_RUN;
                    mcand_d = mul.a;
                    acc_d   = {{N{1'b0}}, mul.b};
                    count_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d   = acc_shift;
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    state_d   = S_DONE;
                    product_d = acc_shift;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign mul.busy    = busy_q;
    assign mul.done    = done_q;
    assign mul.product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed vector table plus hand-written sequences for restart, reset and back-to-back cases.
module tb_shift_add_multiplier;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    shift_add_multiplier_if #(.N(8)) bus ();

    shift_add_multiplier #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mul   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advances one edge at a time until done is seen; lat counts edges.
    task automatic wait_done(output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_vec(input logic [7:0] va, input logic [7:0] vb,
                           input logic [15:0] exp, input string tag);
        logic [15:0] prev;
        int          lat;
        int          busy_cnt;
        bit          hold_ok;
        bit          got;
        prev      = bus.product;
        bus.a     = va;
        bus.b     = vb;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = ~va;
        bus.b     = ~vb;
        lat       = 0;
        busy_cnt  = 0;
        hold_ok   = 1'b1;
        got       = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            if (bus.busy) busy_cnt++;
            if (bus.product !== prev) hold_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'd8);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        check({tag, "_product_hold"}, 32'(hold_ok), 32'd1);
        check({tag, "_product"}, 32'(bus.product), 32'(exp));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_product_kept"}, 32'(bus.product), 32'(exp));
    endtask

    initial begin
        int lat;
        bit got;
        checks = 0;
        errors = 0;

        vecs[0] = '{a: 8'd13,  b: 8'd11,  p: 16'd143};
        vecs[1] = '{a: 8'd255, b: 8'd255, p: 16'hFE01};
        vecs[2] = '{a: 8'd0,   b: 8'd200, p: 16'd0};
        vecs[3] = '{a: 8'd200, b: 8'd0,   p: 16'd0};
        vecs[4] = '{a: 8'd1,   b: 8'd1,   p: 16'd1};
        vecs[5] = '{a: 8'd255, b: 8'd1,   p: 16'd255};
        vecs[6] = '{a: 8'd128, b: 8'd2,   p: 16'd256};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #12;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_product", 32'(bus.product), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++)
            run_vec(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

        // Start pulse and operand change in the middle of RUN are ignored.
        bus.a = 8'd6; bus.b = 8'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = 8'd99; bus.b = 8'd77;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.a = 8'd0; bus.b = 8'd0;
        wait_done(lat, got);
        check("restart_done_seen", 32'(got), 32'd1);
        check("restart_latency", 32'(lat), 32'd5);
        check("restart_product", 32'(bus.product), 32'd42);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of RUN.
        bus.a = 8'd100; bus.b = 8'd3; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_product", 32'(bus.product), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_idle_done", 32'(bus.done), 32'd0);
        check("postrst_idle_busy", 32'(bus.busy), 32'd0);
        run_vec(8'd5, 8'd5, 16'd25, "postrst");

        // start held high: re-accepted in each DONE cycle.
        bus.a = 8'd2; bus.b = 8'd3; bus.start = 1'b1;
        wait_done(lat, got);
        check("b2b_first_seen", 32'(got), 32'd1);
        check("b2b_first_latency", 32'(lat), 32'd9);
        check("b2b_first_product", 32'(bus.product), 32'd6);
        bus.a = 8'd4; bus.b = 8'd5;
        wait_done(lat, got);
        check("b2b_second_seen", 32'(got), 32'd1);
        check("b2b_spacing", 32'(lat), 32'd9);
        check("b2b_second_product", 32'(bus.product), 32'd20);
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("b2b_end_done", 32'(bus.done), 32'd0);
        check("b2b_end_busy", 32'(bus.busy), 32'd0);
        check("b2b_end_product", 32'(bus.product), 32'd20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
